// File: rtl/mem_responder_if.sv
// Request/response bus between the control datapath and mem_responder.
//   req, wr, Address, WriteData : request from the master
//   ReadData, ready, err, busy  : response/status from the slave
interface mem_responder_if;
  logic        req;
  logic        wr;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        ready;
  logic        err;
  logic        busy;

  modport master (
    output req, wr, Address, WriteData,
    input  ReadData, ready, err, busy
  );

  modport slave (
    input  req, wr, Address, WriteData,
    output ReadData, ready, err, busy
  );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed memory responder with fixed read latency.
//   Clk   : single clock, all state on the rising edge
//   Reset : synchronous active-low reset (does not touch memory contents)
//   bus   : slave side of mem_responder_if
//           writes complete in one cycle, reads respond READ_LATENCY cycles after
//           acceptance, misaligned accesses answer immediately with err=1.
module mem_responder #(
  parameter int unsigned DEPTH_WORDS  = 256,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  mem_responder_if.slave   bus
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LatW = 4'(READ_LATENCY);

  typedef enum logic [0:0] {StIdle, StRdWait} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] data_q, data_d;    // word captured at read acceptance
  logic [31:0] rdata_q, rdata_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;

  // Memory powers up cleared; reset deliberately leaves it alone.
  logic [31:0] mem_q [DEPTH_WORDS] = '{default: '0};

  logic [IdxW-1:0] idx;
  logic            aligned;
  logic            accept;
  logic            mem_we;
  logic            unused_addr;

  // Upper address bits alias onto the same words (wrap modulo 4*DEPTH_WORDS).
  assign idx         = bus.Address[IdxW+1:2];
  assign unused_addr = ^bus.Address[31:IdxW+2];
  assign aligned     = (bus.Address[1:0] == 2'b00);
  assign accept      = bus.req & (state_q == StIdle);
  // Reset wins over a write arriving at the same edge.
  assign mem_we      = accept & bus.wr & aligned & Reset;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (!aligned) begin
            ready_d = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
          end else if (bus.wr) begin
            ready_d = 1'b1;
          end else if (READ_LATENCY == 1) begin
            ready_d = 1'b1;
            rdata_d = mem_q[idx];
          end else begin
            state_d = StRdWait;
            cnt_d   = 4'd1;
            data_d  = mem_q[idx];
          end
        end
      end
      StRdWait: begin
        if (cnt_q + 4'd1 == LatW) begin
          state_d = StIdle;
          cnt_d   = '0;
          ready_d = 1'b1;
          rdata_d = data_q;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem_q[idx] <= bus.WriteData;
    end
  end

  assign bus.ReadData = rdata_q;
  assign bus.ready    = ready_q;
  assign bus.err      = err_q;
  assign bus.busy     = (state_q == StRdWait);

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (DEPTH_WORDS=256, READ_LATENCY=2).
module tb_mem_responder;

  localparam int unsigned Lat = 2;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mem_responder_if bus ();

  mem_responder #(
    .DEPTH_WORDS  (256),
    .READ_LATENCY (Lat)
  ) dut (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic req, input logic wr, input logic [31:0] a,
                       input logic [31:0] d);
    bus.req       = req;
    bus.wr        = wr;
    bus.Address   = a;
    bus.WriteData = d;
  endtask

  task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d);
    drive(1'b1, 1'b1, a, d);
    tick();
    drive(1'b0, 1'b0, '0, '0);
    check_eq({tag, "_wr_ready"}, 32'(bus.ready), 32'd1);
    check_eq({tag, "_wr_err"}, 32'(bus.err), 32'd0);
    tick();
  endtask

  task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
    int n;
    drive(1'b1, 1'b0, a, '0);
    tick();
    drive(1'b0, 1'b0, '0, '0);
    n = 1;
    while (!bus.ready && n < 20) begin
      tick();
      n++;
    end
    check_eq({tag, "_rd_ready"}, 32'(bus.ready), 32'd1);
    check_eq({tag, "_rd_latency"}, 32'(n), 32'(Lat));
    check_eq({tag, "_rd_data"}, bus.ReadData, exp);
    check_eq({tag, "_rd_err"}, 32'(bus.err), 32'd0);
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive(1'b0, 1'b0, '0, '0);
    tick();
    tick();
    check_eq("rst_rdata", bus.ReadData, 32'h0);
    check_eq("rst_ready", 32'(bus.ready), 32'd0);
    check_eq("rst_err", 32'(bus.err), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    tick();

    // Write then read back-to-back, checking cycle-exact busy/ready.
    drive(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    tick();
    check_eq("wb_wr_ready", 32'(bus.ready), 32'd1);
    check_eq("wb_wr_err", 32'(bus.err), 32'd0);
    check_eq("wb_wr_busy", 32'(bus.busy), 32'd0);
    check_eq("wb_wr_rdata_hold", bus.ReadData, 32'h0);
    drive(1'b1, 1'b0, 32'h10, '0);
    tick();
    drive(1'b0, 1'b0, '0, '0);
    check_eq("wb_c2_busy", 32'(bus.busy), 32'd1);
    check_eq("wb_c2_ready", 32'(bus.ready), 32'd0);
    tick();
    check_eq("wb_c3_ready", 32'(bus.ready), 32'd1);
    check_eq("wb_c3_err", 32'(bus.err), 32'd0);
    check_eq("wb_c3_data", bus.ReadData, 32'hDEADBEEF);
    check_eq("wb_c3_busy", 32'(bus.busy), 32'd0);
    tick();
    check_eq("wb_c4_ready", 32'(bus.ready), 32'd0);
    check_eq("wb_c4_data_hold", bus.ReadData, 32'hDEADBEEF);

    // Misaligned read and write.
    drive(1'b1, 1'b0, 32'h12, '0);
    tick();
    drive(1'b0, 1'b0, '0, '0);
    check_eq("mis_rd_ready", 32'(bus.ready), 32'd1);
    check_eq("mis_rd_err", 32'(bus.err), 32'd1);
    check_eq("mis_rd_data", bus.ReadData, 32'h0);
    check_eq("mis_rd_busy", 32'(bus.busy), 32'd0);
    tick();
    check_eq("mis_rd_ready_low", 32'(bus.ready), 32'd0);
    check_eq("mis_rd_err_low", 32'(bus.err), 32'd0);
    drive(1'b1, 1'b1, 32'h13, 32'hFFFFFFFF);
    tick();
    drive(1'b0, 1'b0, '0, '0);
    check_eq("mis_wr_err", 32'(bus.err), 32'd1);
    check_eq("mis_wr_busy", 32'(bus.busy), 32'd0);
    tick();
    do_read("mis_keep", 32'h10, 32'hDEADBEEF);

    // Request while busy is dropped.
    drive(1'b1, 1'b0, 32'h20, '0);
    tick();
    check_eq("drop_busy", 32'(bus.busy), 32'd1);
    drive(1'b1, 1'b1, 32'h24, 32'hA5A5A5A5);
    tick();
    drive(1'b0, 1'b0, '0, '0);
    check_eq("drop_rd_ready", 32'(bus.ready), 32'd1);
    check_eq("drop_rd_data", bus.ReadData, 32'h0);
    tick();
    check_eq("drop_no_resp", 32'(bus.ready), 32'd0);
    tick();
    do_read("drop_mem", 32'h24, 32'h0);

    // Address wrap.
    do_write("wrap", 32'h400, 32'h12345678);
    do_read("wrap", 32'h0, 32'h12345678);

    // Reset aborts a pending read.
    drive(1'b1, 1'b0, 32'h10, '0);
    tick();
    drive(1'b0, 1'b0, '0, '0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("abort_c2_ready", 32'(bus.ready), 32'd0);
    check_eq("abort_c2_data", bus.ReadData, 32'h0);
    check_eq("abort_c2_busy", 32'(bus.busy), 32'd0);
    tick();
    check_eq("abort_c3_ready", 32'(bus.ready), 32'd0);
    tick();
    do_read("abort_keep", 32'h10, 32'hDEADBEEF);

    // Write at a reset edge is not committed.
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 32'h40, 32'h00000001);
    tick();
    drive(1'b0, 1'b0, '0, '0);
    rst_n = 1'b1;
    check_eq("rstwr_ready", 32'(bus.ready), 32'd0);
    tick();
    do_read("rstwr_mem", 32'h40, 32'h0);

    // Back-to-back reads reuse the response cycle.
    do_write("b2b", 32'h14, 32'h0BADF00D);
    drive(1'b1, 1'b0, 32'h10, '0);
    tick();
    drive(1'b0, 1'b0, '0, '0);
    check_eq("b2b_c1_ready", 32'(bus.ready), 32'd0);
    tick();
    check_eq("b2b_c2_ready", 32'(bus.ready), 32'd1);
    check_eq("b2b_c2_data", bus.ReadData, 32'hDEADBEEF);
    check_eq("b2b_c2_busy", 32'(bus.busy), 32'd0);
    drive(1'b1, 1'b0, 32'h14, '0);
    tick();
    drive(1'b0, 1'b0, '0, '0);
    check_eq("b2b_c3_ready", 32'(bus.ready), 32'd0);
    check_eq("b2b_c3_busy", 32'(bus.busy), 32'd1);
    tick();
    check_eq("b2b_c4_ready", 32'(bus.ready), 32'd1);
    check_eq("b2b_c4_data", bus.ReadData, 32'h0BADF00D);
    tick();
    check_eq("b2b_c5_ready", 32'(bus.ready), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
